// File: rtl/rr_grant_enc.sv
// Round-robin arbiter: picks one active requester starting at ptr and presents it as a
// registered binary index with a valid/ack handshake; the search start advances past each acked winner.
module rr_grant_enc #(
    parameter  int   REQ = 8,
    parameter  logic ACT = 1'b1,
    localparam int   OUT = $clog2(REQ)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [REQ-1:0] req,
    input  logic           ack,
    output logic           valid,
    output logic [OUT-1:0] grant_idx,
    output logic [OUT-1:0] ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic           valid_q, valid_d;
    logic [OUT-1:0] grant_idx_q, grant_idx_d;
    logic [OUT-1:0] ptr_q, ptr_d;

    logic [REQ-1:0] req_act_s;
    logic [OUT-1:0] ptr_next_s;
    logic [OUT:0]   pick_idle_s;
    logic [OUT:0]   pick_ack_s;

    // Returns {found, index} of the first active bit in cyclic order start..REQ-1, 0..start-1.
    // The wrap is at REQ, so indices >= REQ are never produced.
    function automatic logic [OUT:0] rr_pick(input logic [REQ-1:0] act, input logic [OUT-1:0] start);
        logic           found;
        logic [OUT-1:0] idx;
        int             pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < REQ; k++) begin
            pos = int'(start) + k;
            if (pos >= REQ) begin
                pos = pos - REQ;
            end else begin
                pos = pos;
            end
            if (!found && act[pos]) begin
                found = 1'b1;
                idx   = OUT'(pos);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Normalise request polarity and compute both candidate selections.
    always_comb begin
        if (ACT == 1'b1) begin
            req_act_s = req;
        end else begin
            req_act_s = ~req;
        end
        if (grant_idx_q == OUT'(REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_q + OUT'(1);
        end
        pick_idle_s = rr_pick(req_act_s, ptr_q);
        pick_ack_s  = rr_pick(req_act_s, ptr_next_s);
    end

    // Next-state logic for the IDLE/GRANT handshake.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_idle_s[OUT]) begin
                    state_d     = GRANT;
                    valid_d     = 1'b1;
                    grant_idx_d = pick_idle_s[OUT-1:0];
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Held grant is never withdrawn; only an ack moves it.
                if (ack) begin
                    ptr_d = ptr_next_s;
                    if (pick_ack_s[OUT]) begin
                        state_d     = GRANT;
                        valid_d     = 1'b1;
                        grant_idx_d = pick_ack_s[OUT-1:0];
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

    assign valid     = valid_q;
    assign grant_idx = grant_idx_q;
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_rr_grant_enc.sv
// Scoreboard bench for rr_grant_enc: three instances (REQ=8 active-high, REQ=5, active-low)
// with expected outputs queued as each stimulus cycle is driven.
module tb_rr_grant_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic [7:0] req0, req2;
    logic [4:0] req1;
    logic       ack0, ack1, ack2;
    logic       val0, val1, val2;
    logic [2:0] g0, g1, g2;
    logic [2:0] p0, p1, p2;

    rr_grant_enc #(.REQ(8), .ACT(1'b1)) dut0 (
        .clk(clk), .reset(rst0), .req(req0), .ack(ack0),
        .valid(val0), .grant_idx(g0), .ptr(p0)
    );
    rr_grant_enc #(.REQ(5), .ACT(1'b1)) dut1 (
        .clk(clk), .reset(rst1), .req(req1), .ack(ack1),
        .valid(val1), .grant_idx(g1), .ptr(p1)
    );
    rr_grant_enc #(.REQ(8), .ACT(1'b0)) dut2 (
        .clk(clk), .reset(rst2), .req(req2), .ack(ack2),
        .valid(val2), .grant_idx(g2), .ptr(p2)
    );

    typedef struct {
        int         sel;
        logic       v;
        logic [2:0] g;
        logic [2:0] p;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on instance sel, queue the expected post-edge outputs, then compare.
    task automatic step(input int sel, input logic rs, input logic [7:0] rq, input logic ak,
                        input logic ev, input logic [2:0] eg, input logic [2:0] ep, input string tag);
        exp_t e;
        logic       ov;
        logic [2:0] og, op;
        @(negedge clk);
        case (sel)
            0:       begin rst0 = rs; req0 = rq;      ack0 = ak; end
            1:       begin rst1 = rs; req1 = rq[4:0]; ack1 = ak; end
            default: begin rst2 = rs; req2 = rq;      ack2 = ak; end
        endcase
        e.sel = sel; e.v = ev; e.g = eg; e.p = ep; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        case (e.sel)
            0:       begin ov = val0; og = g0; op = p0; end
            1:       begin ov = val1; og = g1; op = p1; end
            default: begin ov = val2; og = g2; op = p2; end
        endcase
        check_val({e.tag, ".valid"}, int'(ov), int'(e.v));
        check_val({e.tag, ".grant"}, int'(og), int'(e.g));
        check_val({e.tag, ".ptr"},   int'(op), int'(e.p));
    endtask

    initial begin
        logic [7:0] onehot;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        req0 = 8'h00; req1 = 5'h00; req2 = 8'hFF;
        ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;

        // Reset wins over requests and ack.
        step(0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 3'd0, "rst_a");
        step(0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 3'd0, "rst_b");
        rst1 = 1'b0; rst2 = 1'b0;

        // Single requester 5, held with no withdraw when req drops.
        step(0, 1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 3'd0, "single");
        step(0, 1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 3'd0, "hold1");
        step(0, 1'b0, 8'h20, 1'b0, 1'b1, 3'd5, 3'd0, "hold2");
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 3'd0, "hold3");
        step(0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 3'd0, "hold4");
        onehot = 8'd1 << g0;
        check_val("bin_dec", int'(onehot), 32'h20);
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 3'd6, "ack5");
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5, 3'd6, "idle_ack");

        // All requesting with continuous ack: strict rotation through the wrap.
        step(0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0, "rst_c");
        step(0, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd0, 3'd0, "all_first");
        for (int k = 1; k <= 15; k++) begin
            step(0, 1'b0, 8'hFF, 1'b1, 1'b1, 3'(k % 8), 3'(k % 8), "rotate");
        end

        // Requesters 0 and 7 alternate after 7 is acked.
        step(0, 1'b0, 8'h81, 1'b1, 1'b1, 3'd0, 3'd0, "wrap0");
        step(0, 1'b0, 8'h81, 1'b1, 1'b1, 3'd7, 3'd1, "wrap7");
        step(0, 1'b0, 8'h81, 1'b1, 1'b1, 3'd0, 3'd0, "wrap0b");
        step(0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd1, "drain");

        // REQ=5: pointer wraps past index 4 to 0.
        step(1, 1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 3'd0, "r5_g4");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 3'd0, "r5_wrap");
        step(1, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 3'd0, "r5_g0");
        step(1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 3'd1, "r5_ack0");
        step(1, 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 3'd1, "r5_search");

        // Active-low requests, then reset during GRANT with a pending ack.
        step(2, 1'b0, 8'hFB, 1'b0, 1'b1, 3'd2, 3'd0, "low_g2");
        step(2, 1'b0, 8'hFF, 1'b1, 1'b0, 3'd2, 3'd3, "low_ack");
        step(2, 1'b0, 8'hFB, 1'b0, 1'b1, 3'd2, 3'd3, "low_g2b");
        step(2, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd2, 3'd3, "low_hold");
        step(2, 1'b1, 8'hFB, 1'b1, 1'b0, 3'd0, 3'd0, "low_rst");
        step(2, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 3'd0, "low_drop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
